// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and helpers for the PS/2 host-to-device transmitter.
//   ps2_state_e    - transmitter FSM states
//   us_to_cycles() - converts a duration in microseconds to clock cycles
//   odd_parity()   - PS/2 parity bit for a data byte (odd parity)
//   PS2_CMD_*      - common mouse command bytes
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StSend,
        StAck,
        StWaitIdle,
        StError
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

    // Index of the stop bit in the shifted frame (0-7 data, 8 parity, 9 stop).
    localparam logic [3:0] STOP_IDX = 4'd9;

    // 64-bit intermediate: 15000 us at 100 MHz overflows 32 bits before the divide.
    function automatic int unsigned us_to_cycles(input longint unsigned us,
                                                 input longint unsigned freq);
        longint unsigned cyc;
        cyc = (us * freq) / 64'd1_000_000;
        return cyc[31:0];
    endfunction

    // Parity bit that makes the total number of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one asynchronous PS/2 line.
//   2-FF synchronizer, then a stable-level filter that only accepts a new level after
//   FILT_CYCLES consecutive synchronized samples at that level, then a 1->0 pulse.
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset (line assumed idle-high at reset)
//   line_i   raw pad value, asynchronous
//   level_o  filtered line level
//   fall_o   one-cycle pulse in the first cycle level_o reads 0 after a 1
module ps2_line_filter #(
    parameter int unsigned FILT_CYCLES = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int unsigned CntW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

    logic [1:0]      sync_q;
    logic            level_q;
    logic [CntW-1:0] cnt_q;
    logic            fall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            fall_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                // Any sample agreeing with the current level restarts the run.
                cnt_q <= '0;
            end else if (cnt_q == CntW'(FILT_CYCLES - 1)) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
                // Level was 1 and is flipping, so this is a falling transition.
                fall_q  <= level_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (one byte per request).
//   Inhibits the clock, issues request-to-send, shifts data + odd parity + stop on the
//   device clock, then checks the device ACK. Lines are open-drain: *_oe = 1 pulls low.
// Ports:
//   clk100MHz    system clock
//   rst          asynchronous active-low reset
//   tx_valid     command request, accepted when tx_ready is high
//   tx_data      command byte
//   tx_ready     idle and able to accept a command
//   ps2_clk_in   raw ps2_clk pad value (asynchronous)
//   ps2_data_in  raw ps2_data pad value (asynchronous)
//   ps2_clk_oe   1 = drive ps2_clk low
//   ps2_data_oe  1 = drive ps2_data low
//   busy         transaction in progress (receiver ignores line activity)
//   done         one-cycle pulse: ACK received
//   err          one-cycle pulse: timeout or missing ACK
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned INHIBIT_US  = 120,
    parameter int unsigned FILT_CYCLES = 8,
    parameter int unsigned TIMEOUT_US  = 15000
) (
    input  logic       clk100MHz,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned InhCycles = us_to_cycles(64'(INHIBIT_US), 64'(CLK_FREQ_HZ));
    localparam int unsigned ToCycles  = us_to_cycles(64'(TIMEOUT_US), 64'(CLK_FREQ_HZ));
    localparam int unsigned InhW      = $clog2(InhCycles + 1);
    localparam int unsigned ToW       = $clog2(ToCycles + 1);

    // Input conditioning
    logic       clk_level;
    logic       clk_fall;
    logic [1:0] data_sync_q;

    ps2_line_filter #(
        .FILT_CYCLES (FILT_CYCLES)
    ) u_clk_filter (
        .clk_i   (clk100MHz),
        .rst_ni  (rst),
        .line_i  (ps2_clk_in),
        .level_o (clk_level),
        .fall_o  (clk_fall)
    );

    // Data is only sampled at ACK and idle-checked, so a plain synchronizer suffices.
    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) begin
            data_sync_q <= 2'b11;
        end else begin
            data_sync_q <= {data_sync_q[0], ps2_data_in};
        end
    end

    logic data_sync;
    assign data_sync = data_sync_q[1];

    // Transmitter state
    ps2_state_e      state_q;
    logic [7:0]      data_q;
    logic            parity_q;
    logic [3:0]      bit_idx_q;
    logic [InhW-1:0] inh_cnt_q;
    logic [ToW-1:0]  to_cnt_q;
    logic            tx_ready_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic            clk_oe_q;
    logic            data_oe_q;

    // Level of the frame bit selected by bit_idx_q; index 9 (stop) is a released 1.
    logic frame_bit;
    always_comb begin
        frame_bit = 1'b1;
        if (bit_idx_q < 4'd8) begin
            frame_bit = data_q[bit_idx_q[2:0]];
        end else if (bit_idx_q == 4'd8) begin
            frame_bit = parity_q;
        end
    end

    logic timeout_hit;
    assign timeout_hit = (to_cnt_q == ToW'(ToCycles - 1));

    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            data_q     <= '0;
            parity_q   <= 1'b0;
            bit_idx_q  <= '0;
            inh_cnt_q  <= '0;
            to_cnt_q   <= '0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Entered with tx_ready low after done; raise it one cycle later.
                    tx_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    if (tx_valid && tx_ready_q) begin
                        data_q     <= tx_data;
                        parity_q   <= odd_parity(tx_data);
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        clk_oe_q   <= 1'b1;
                        inh_cnt_q  <= '0;
                        state_q    <= StInhibit;
                    end
                end

                StInhibit: begin
                    if (inh_cnt_q == InhW'(InhCycles - 1)) begin
                        data_oe_q <= 1'b1;
                        state_q   <= StRts;
                    end else begin
                        inh_cnt_q <= inh_cnt_q + 1'b1;
                    end
                end

                StRts: begin
                    // Start bit stays driven; releasing the clock hands it to the device.
                    clk_oe_q  <= 1'b0;
                    to_cnt_q  <= '0;
                    bit_idx_q <= '0;
                    state_q   <= StSend;
                end

                StSend: begin
                    if (timeout_hit) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= StError;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                        if (clk_fall) begin
                            data_oe_q <= ~frame_bit;
                            if (bit_idx_q == STOP_IDX) begin
                                state_q <= StAck;
                            end else begin
                                bit_idx_q <= bit_idx_q + 1'b1;
                            end
                        end
                    end
                end

                StAck: begin
                    if (timeout_hit) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= StError;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                        if (clk_fall) begin
                            if (!data_sync) begin
                                state_q <= StWaitIdle;
                            end else begin
                                clk_oe_q  <= 1'b0;
                                data_oe_q <= 1'b0;
                                err_q     <= 1'b1;
                                state_q   <= StError;
                            end
                        end
                    end
                end

                StWaitIdle: begin
                    if (timeout_hit) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= StError;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                        if (clk_level && data_sync) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                end

                StError: begin
                    // err is high during this state; ready returns the cycle after.
                    tx_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= StIdle;
                end

                default: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    assign tx_ready    = tx_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule
